// File: rtl/shift_add_mult_ctrl_if.sv
// Operand/result handshake bundle for the sequential shift-add multiplier.
// The master side presents operands and consumes products; the slave side is the multiplier.
interface shift_add_mult_ctrl_if #(
    parameter int unsigned M_WIDTH = 3,
    parameter int unsigned Q_WIDTH = 2
);
    localparam int unsigned P_WIDTH = M_WIDTH + Q_WIDTH;
    localparam int unsigned CNT_W   = (Q_WIDTH > 1) ? $clog2(Q_WIDTH) : 1;

    logic               start_valid;
    logic               start_ready;
    logic [M_WIDTH-1:0] m_in;
    logic [Q_WIDTH-1:0] q_in;
    logic               result_valid;
    logic               result_ready;
    logic [P_WIDTH-1:0] product;
    logic               busy;
    logic [CNT_W-1:0]   row_idx;

    modport master (
        output start_valid,
        output m_in,
        output q_in,
        output result_ready,
        input  start_ready,
        input  result_valid,
        input  product,
        input  busy,
        input  row_idx
    );

    modport slave (
        input  start_valid,
        input  m_in,
        input  q_in,
        input  result_ready,
        output start_ready,
        output result_valid,
        output product,
        output busy,
        output row_idx
    );
endinterface

// File: rtl/shift_add_mult_ctrl.sv
// Unsigned M x Q multiplier that accumulates one shifted partial-product row per clock,
// with valid/ready handshakes on both the operand and the result side.
module shift_add_mult_ctrl #(
    parameter int unsigned M_WIDTH = 3,
    parameter int unsigned Q_WIDTH = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    shift_add_mult_ctrl_if.slave  bus_io
);
    localparam int unsigned P_WIDTH = M_WIDTH + Q_WIDTH;
    localparam int unsigned CNT_W   = (Q_WIDTH > 1) ? $clog2(Q_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LastRow = CNT_W'(Q_WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [M_WIDTH-1:0] m_q, m_d;
    logic [Q_WIDTH-1:0] q_q, q_d;
    logic [P_WIDTH-1:0] acc_q, acc_d;
    logic [P_WIDTH-1:0] product_q, product_d;
    logic [CNT_W-1:0]   row_idx_q, row_idx_d;

    logic [P_WIDTH-1:0] addend;
    logic [P_WIDTH-1:0] sum;

    // Single reused partial-product row; shift stays below Q_WIDTH so nothing is lost.
    always_comb begin
        addend = '0;
        if (q_q[row_idx_q]) begin
            addend = P_WIDTH'(m_q) << row_idx_q;
        end
        sum = acc_q + addend;
    end

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        q_d       = q_q;
        acc_d     = acc_q;
        product_d = product_q;
        row_idx_d = row_idx_q;
        unique case (state_q)
            StIdle: begin
                if (bus_io.start_valid) begin
                    m_d       = bus_io.m_in;
                    q_d       = bus_io.q_in;
                    acc_d     = '0;
                    row_idx_d = '0;
                    state_d   = StAccum;
                end
            end
            StAccum: begin
                acc_d = sum;
                if (row_idx_q == LastRow) begin
                    product_d = sum;
                    state_d   = StDone;
                end else begin
                    row_idx_d = row_idx_q + CNT_W'(1);
                end
            end
            StDone: begin
                // A start presented here waits for the following idle cycle.
                if (bus_io.result_ready) begin
                    row_idx_d = '0;
                    state_d   = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            m_q       <= '0;
            q_q       <= '0;
            acc_q     <= '0;
            product_q <= '0;
            row_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            q_q       <= q_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            row_idx_q <= row_idx_d;
        end
    end

    // Every output is a register or a pure decode of the state register.
    assign bus_io.start_ready  = (state_q == StIdle);
    assign bus_io.result_valid = (state_q == StDone);
    assign bus_io.busy         = (state_q != StIdle);
    assign bus_io.product      = product_q;
    assign bus_io.row_idx      = row_idx_q;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Scoreboard bench for shift_add_mult_ctrl: expected products are queued on accept and
// compared when the result handshake is observed.
module tb_shift_add_mult_ctrl;
    localparam int unsigned M_WIDTH = 3;
    localparam int unsigned Q_WIDTH = 2;
    localparam int unsigned P_WIDTH = M_WIDTH + Q_WIDTH;
    localparam int          LAT     = Q_WIDTH;

    logic clock;
    logic reset_n;
    int   n_vec;
    int   n_err;

    logic [P_WIDTH-1:0] exp_q[$];

    shift_add_mult_ctrl_if #(.M_WIDTH(M_WIDTH), .Q_WIDTH(Q_WIDTH)) bus ();

    shift_add_mult_ctrl #(.M_WIDTH(M_WIDTH), .Q_WIDTH(Q_WIDTH)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus_io (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present operands in IDLE, take one edge to accept, then scramble the operand pins.
    task automatic issue(input logic [M_WIDTH-1:0] m, input logic [Q_WIDTH-1:0] q);
        logic [P_WIDTH-1:0] e;
        bus.start_valid = 1'b1;
        bus.m_in        = m;
        bus.q_in        = q;
        step();
        bus.start_valid = 1'b0;
        bus.m_in        = '0;
        bus.q_in        = '0;
        e = P_WIDTH'(m) * P_WIDTH'(q);
        exp_q.push_back(e);
    endtask

    task automatic wait_result(output int cycles);
        cycles = 0;
        while (!bus.result_valid && cycles < 20) begin
            step();
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset_n         = 1'b0;
        bus.start_valid = 1'b1;
        bus.m_in        = 3'b111;
        bus.q_in        = 2'b11;
        bus.result_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_vec++;
            if (bus.start_ready !== 1'b1 || bus.result_valid !== 1'b0 || bus.busy !== 1'b0 ||
                bus.product !== '0) begin
                n_err++;
                $display("FAIL reset cyc%0d: rdy=%b vld=%b busy=%b prod=%0d, want 1 0 0 0",
                         i, bus.start_ready, bus.result_valid, bus.busy, bus.product);
            end
        end
        bus.start_valid = 1'b0;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_max_operands();
        int                 cyc;
        logic [P_WIDTH-1:0] e;
        issue(3'b111, 2'b11);
        n_vec++;
        if (bus.busy !== 1'b1 || bus.row_idx !== '0) begin
            n_err++;
            $display("FAIL max_accept: busy=%b row=%0d, want 1 0", bus.busy, bus.row_idx);
        end
        wait_result(cyc);
        n_vec++;
        if (cyc !== LAT) begin
            n_err++;
            $display("FAIL max_latency: got %0d cycles, want %0d", cyc, LAT);
        end
        e = exp_q.pop_front();
        n_vec++;
        if (bus.product !== e || e !== 5'd21) begin
            n_err++;
            $display("FAIL max_product: got %0d, want 21", bus.product);
        end
        bus.result_ready = 1'b1;
        step();
        bus.result_ready = 1'b0;
        n_vec++;
        if (bus.result_valid !== 1'b0 || bus.start_ready !== 1'b1 || bus.product !== e) begin
            n_err++;
            $display("FAIL max_release: vld=%b rdy=%b prod=%0d, want 0 1 %0d",
                     bus.result_valid, bus.start_ready, bus.product, e);
        end
    endtask

    task automatic test_mixed();
        logic [M_WIDTH-1:0] ms [2] = '{3'b101, 3'b000};
        logic [Q_WIDTH-1:0] qs [2] = '{2'b10, 2'b11};
        int                 cyc;
        logic [P_WIDTH-1:0] e;
        for (int i = 0; i < 2; i++) begin
            issue(ms[i], qs[i]);
            wait_result(cyc);
            n_vec++;
            if (cyc !== LAT) begin
                n_err++;
                $display("FAIL mixed%0d_latency: got %0d, want %0d", i, cyc, LAT);
            end
            e = exp_q.pop_front();
            n_vec++;
            if (bus.product !== e) begin
                n_err++;
                $display("FAIL mixed%0d_product: got %0d, want %0d", i, bus.product, e);
            end
            bus.result_ready = 1'b1;
            step();
            bus.result_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        int                 cyc;
        logic [P_WIDTH-1:0] e;
        issue(3'b011, 2'b01);
        wait_result(cyc);
        e = exp_q.pop_front();
        bus.start_valid = 1'b1;
        bus.m_in        = 3'b101;
        bus.q_in        = 2'b11;
        for (int i = 0; i < 10; i++) begin
            n_vec++;
            if (bus.result_valid !== 1'b1 || bus.product !== e || bus.start_ready !== 1'b0 ||
                bus.busy !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold%0d: vld=%b prod=%0d rdy=%b busy=%b, want 1 %0d 0 1",
                         i, bus.result_valid, bus.product, bus.start_ready, bus.busy, e);
            end
            step();
        end
        bus.result_ready = 1'b1;
        step();
        bus.result_ready = 1'b0;
        n_vec++;
        if (bus.start_ready !== 1'b1 || bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL bp_idle: rdy=%b vld=%b busy=%b, want 1 0 0",
                     bus.start_ready, bus.result_valid, bus.busy);
        end
        step();
        exp_q.push_back(5'd15);
        bus.start_valid = 1'b0;
        bus.m_in        = '0;
        bus.q_in        = '0;
        n_vec++;
        if (bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL bp_held_accept: busy=%b, want 1", bus.busy);
        end
        wait_result(cyc);
        e = exp_q.pop_front();
        n_vec++;
        if (bus.product !== e || cyc !== LAT) begin
            n_err++;
            $display("FAIL bp_second: prod=%0d cyc=%0d, want %0d %0d", bus.product, cyc, e, LAT);
        end
        bus.result_ready = 1'b1;
        step();
        bus.result_ready = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        int                 cyc;
        logic [P_WIDTH-1:0] e;
        issue(3'b111, 2'b11);
        reset_n = 1'b0;
        step();
        exp_q.delete();
        n_vec++;
        if (bus.start_ready !== 1'b1 || bus.busy !== 1'b0 || bus.product !== '0 ||
            bus.row_idx !== '0) begin
            n_err++;
            $display("FAIL midrst_idle: rdy=%b busy=%b prod=%0d row=%0d, want 1 0 0 0",
                     bus.start_ready, bus.busy, bus.product, bus.row_idx);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (bus.result_valid !== 1'b0) begin
                n_err++;
                $display("FAIL midrst_no_pulse%0d: vld=%b, want 0", i, bus.result_valid);
            end
            step();
        end
        issue(3'b010, 2'b11);
        wait_result(cyc);
        e = exp_q.pop_front();
        n_vec++;
        if (bus.product !== e || e !== 5'd6 || cyc !== LAT) begin
            n_err++;
            $display("FAIL midrst_after: prod=%0d cyc=%0d, want 6 %0d", bus.product, cyc, LAT);
        end
        bus.result_ready = 1'b1;
        step();
        bus.result_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int                 cyc_now;
        int                 accepts;
        int                 results;
        int                 t_acc [2];
        logic               pre_rdy;
        logic               pre_vld;
        logic [P_WIDTH-1:0] pre_prod;
        logic [P_WIDTH-1:0] e;
        accepts          = 0;
        results          = 0;
        cyc_now          = 0;
        bus.result_ready = 1'b1;
        bus.start_valid  = 1'b1;
        bus.m_in         = 3'b110;
        bus.q_in         = 2'b01;
        while (results < 2 && cyc_now < 30) begin
            pre_rdy  = bus.start_ready;
            pre_vld  = bus.result_valid;
            pre_prod = bus.product;
            step();
            cyc_now++;
            if (pre_vld) begin
                results++;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL b2b_unexpected: prod=%0d, want none", pre_prod);
                end else begin
                    e = exp_q.pop_front();
                    if (pre_prod !== e) begin
                        n_err++;
                        $display("FAIL b2b_product%0d: got %0d, want %0d", results, pre_prod, e);
                    end
                end
            end
            if (pre_rdy && bus.start_valid && accepts < 2) begin
                exp_q.push_back(P_WIDTH'(bus.m_in) * P_WIDTH'(bus.q_in));
                t_acc[accepts] = cyc_now;
                accepts++;
                if (accepts == 1) begin
                    bus.m_in = 3'b001;
                    bus.q_in = 2'b10;
                end else begin
                    bus.start_valid = 1'b0;
                    bus.m_in        = '0;
                    bus.q_in        = '0;
                end
            end
        end
        bus.result_ready = 1'b0;
        bus.start_valid  = 1'b0;
        n_vec++;
        if (results !== 2 || accepts !== 2) begin
            n_err++;
            $display("FAIL b2b_count: results=%0d accepts=%0d, want 2 2", results, accepts);
        end else begin
            n_vec++;
            if (t_acc[1] - t_acc[0] !== Q_WIDTH + 2) begin
                n_err++;
                $display("FAIL b2b_spacing: got %0d, want %0d", t_acc[1] - t_acc[0], Q_WIDTH + 2);
            end
        end
    endtask

    initial begin
        n_vec            = 0;
        n_err            = 0;
        reset_n          = 1'b0;
        bus.start_valid  = 1'b0;
        bus.m_in         = '0;
        bus.q_in         = '0;
        bus.result_ready = 1'b0;
        test_reset();
        test_max_operands();
        test_mixed();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/shift_add_mult_ctrl.md
Name: shift_add_mult_ctrl

Overview:
Sequential controller that computes an unsigned M_WIDTH x Q_WIDTH product by reusing a single partial-product row. The row is issued once per cycle, one multiplier bit at a time, instead of instantiating a full array. The block sits beside the combinational array multiplier as its area-reduced, handshaked alternative. Operands enter through a valid/ready handshake, and the result leaves through a second valid/ready handshake.

Parameters:
M_WIDTH, 3, multiplicand width in bits (>=1)
Q_WIDTH, 2, multiplier width in bits (>=1); also the number of accumulate cycles
(derived, not overridable) P_WIDTH = M_WIDTH+Q_WIDTH, product width; CNT_W = max(1, clog2(Q_WIDTH))

Ports:
clock  input  1  system clock, rising-edge
reset_n  input  1  synchronous, active-low reset
start_valid  input  1  requester presents operands
start_ready  output  1  block can accept operands
m_in  input  M_WIDTH  multiplicand, sampled only on accept
q_in  input  Q_WIDTH  multiplier, sampled only on accept
result_valid  output  1  product available
result_ready  input  1  consumer takes product
product  output  P_WIDTH  registered product
busy  output  1  high while in ACCUM or DONE
row_idx  output  CNT_W  index of the row being accumulated (debug/visibility)

Behaviour:
- One clock. Reset is synchronous, active-low, sampled at the rising edge of clock.
- Reset values: state=IDLE; product=0; result_valid=0; start_ready=1 (combinational from state); busy=0; row_idx=0; internal m_reg/q_reg/acc=0.
- Reset asserted mid-operation: at the next edge the block returns to IDLE with all reset values. The in-flight operation is discarded, and no result_valid pulse is produced.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - start_ready=1.
  - On an edge with start_valid=1: latch m_reg<=m_in, q_reg<=q_in, acc<=0, row_idx<=0, then go to ACCUM.
- ACCUM:
  - start_ready=0, busy=1.
  - Each edge: acc <= acc + (q_reg[row_idx] ? (m_reg zero-extended to P_WIDTH) << row_idx : 0).
  - If row_idx==Q_WIDTH-1: product <= that same sum, then go to DONE. Otherwise row_idx <= row_idx+1.
  - Exactly Q_WIDTH cycles are spent in ACCUM, with no zero-skip or early exit.
- DONE:
  - result_valid=1, busy=1, start_ready=0.
  - product is held stable until the handshake completes.
  - On an edge with result_ready=1: go to IDLE, result_valid drops, product keeps its last value, row_idx<=0.
- Latency: accept on edge E0, so result_valid is high in the cycle after edge E0+Q_WIDTH. With the defaults, that is 2 cycles after acceptance.
- Throughput: one product per Q_WIDTH+2 cycles when result_ready is held high. There is no overlap, because start_ready is low in DONE.
- Arithmetic:
  - Unsigned only.
  - acc and product are P_WIDTH wide and cannot overflow, since (2^M-1)(2^Q-1) < 2^P.
  - Shift amounts stay below Q_WIDTH.
- Ignored inputs:
  - start_valid, m_in and q_in are ignored outside IDLE.
  - Changing m_in or q_in after acceptance does not affect the result.
  - result_ready is ignored outside DONE.
- Simultaneous events:
  - start_valid in DONE is not accepted, even on the edge where result_ready completes the handshake. It is accepted in the following IDLE cycle if still held.
  - Reset has priority over every event.
- All outputs are registered, or are decoded purely from the state register. There are no combinational paths from inputs to outputs.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with start_valid=1, m_in=3'b111, q_in=2'b11. Required: start_ready=1, result_valid=0, busy=0, product=5'b00000 throughout.
- Max operands: accept m_in=3'b111, q_in=2'b11. Required: result_valid rises exactly 2 cycles after accept, product=5'b10101 (21). Operands are changed to 0 the cycle after accept, and the result must be unaffected.
- Mixed operands: m_in=3'b101, q_in=2'b10 -> product=5'b01010 (10). m_in=3'b000, q_in=2'b11 -> product=0, but the full 2-cycle latency still applies.
- Backpressure: product m=3'b011, q=2'b01, with result_ready=0 for 10 cycles and start_valid held high. Required: result_valid stays 1, product stays 5'b00011, start_ready stays 0, and no new accept occurs. After result_ready=1 for one edge, the state is IDLE and the held start is accepted on the following edge.
- Reset mid-operation: accept m=3'b111, q=2'b11, then drive reset_n=0 on the first ACCUM cycle. Required: at the next edge the block is in IDLE, product=0, and result_valid never pulses. A subsequent 3'b010 x 2'b11 gives 5'b00110.
- Back-to-back with result_ready=1: run 3'b110 x 2'b01 then 3'b001 x 2'b10. Required: products 6 then 2, with successive accepts exactly 4 cycles apart.
